// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin select block and its arbiter.
package mux_pkg;

    localparam int NUM_CH_MAX = 16;

    // Select-index width; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [2*NUM_CH-1:0] dbl_req;
    logic [2*NUM_CH-1:0] mask;
    logic [2*NUM_CH-1:0] masked;

    // Doubling the request vector turns the wrap into a plain upward search
    // that starts at ptr in the lower copy and spills into the upper copy.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        dbl_req     = {req, req};
        for (int i = 0; i < 2*NUM_CH; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = dbl_req & mask;
        // Descending scan so the lowest masked index is the last to win.
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'((i >= NUM_CH) ? i - NUM_CH : i);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 round-robin select with valid/ready handshakes and a one-beat output register.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    localparam int SEL_W      = sel_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_sel
);

    if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("rr_arb_mux: NUM_CH out of range");
    end

    logic                  accept;
    logic                  grant_valid;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      ptr_next;
    logic                  load;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arbiter (
        .req         (in_valid),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign accept   = !out_valid || out_ready;
    assign load     = !rst && accept && grant_valid;
    assign ptr_next = (grant_idx == SEL_W'(NUM_CH-1)) ? '0 : SEL_W'(grant_idx + 1'b1);

    // Only the granted channel's slice is read, so X on idle channels never reaches out_data.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = load;
                sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N:1 select block with valid/ready handshakes and a registered output stage; successor to the fixed 4-input combinational select.
- Select index is produced internally by a round-robin arbiter rather than supplied by the caller.
- Used where several requesters share one downstream path, e.g. fetch/LSU/debug sharing the single memory request port.
- Guarantees fairness, single-beat buffering, and stable output under backpressure.

Parameters:
- DATA_WIDTH, 32: payload width per channel.
- NUM_CH, 4: number of input channels, 1..16.
- SEL_W, derived: max(1, $clog2(NUM_CH)). Computed from NUM_CH; never overridden.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel request valid.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_WIDTH  registered payload.
- out_sel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, synchronous-release use assumed upstream):
  - out_valid=0, out_data=0, out_sel=0.
  - Priority pointer ptr=0.
  - in_ready is all zeros while rst=1.
- Stage capacity is one beat.
  - accept = !out_valid || out_ready. This allows full throughput, one beat per cycle.
- Arbitration is combinational each cycle.
  - Search in_valid starting at index ptr, ascending, wrapping from NUM_CH-1 to 0.
  - The first set bit is the grant g.
  - No valid inputs means no grant.
- in_ready[i] = accept && grant_valid && (g == i). At most one bit is set. There is no combinational path from in_valid[i] to in_ready[j] beyond the arbiter.
- Transfer on input i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod NUM_CH. The wrap is explicit; NUM_CH need not be a power of 2.
- Drain: when out_valid && out_ready and there is no new grant, out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and grant: the new beat loads in the same cycle. out_valid stays 1 and there is no bubble.
- Backpressure: while out_valid && !out_ready:
  - out_data, out_sel and ptr hold.
  - All in_ready are 0.
- Latency: 1 cycle from input handshake to out_valid.
- ptr changes only on a grant. Idle cycles leave it unchanged.
- Inputs may drop in_valid without a handshake. The block does not require input stability.
- NUM_CH=1: arbiter degenerates to a pass-through, out_sel is constantly 0, ptr is unused.
- Reset mid-operation: any held beat is discarded and ptr returns to 0. No partial state survives.
- Invalid (X) in_data on non-granted channels must not propagate to out_data.

Decomposition:
- Shared package mux_pkg holds:
  - function sel_width(n) returning max(1, $clog2(n)).
  - NUM_CH_MAX=16 constant for elaboration-time assertion.
- Sub-module rr_arbiter (NUM_CH): inputs req and ptr; outputs grant_valid and grant_idx.
  - Purely combinational, implemented as a double-width masked priority encoder.
  - Reused later by the register-file write-port arbiter.
- Top level holds ptr, the output register, and the handshake logic.

Test Plan:
- Reset and idle: assert rst mid-run with out_valid=1 -> out_valid=0, in_ready=0 immediately (async). After release with all in_valid=0 -> no handshakes, ptr=0.
- Fairness: NUM_CH=4, all in_valid=1, out_ready=1 constantly -> out_sel sequence 0,1,2,3,0,1… one per cycle, out_data matching each channel's value (e.g. 0xA0..0xA3).
- Pointer skip: ptr=1 after grant to 0; in_valid=4'b1001 -> grant 3, then ptr wraps to 0, next grant 0.
- Backpressure: beat 0xDEADBEEF from ch2 held; out_ready=0 for 5 cycles -> out_data/out_sel stable, in_ready=0. Then out_ready=1 with ch3 valid -> ch3 beat loaded the same cycle, no bubble.
- Non-power-of-2: NUM_CH=3, all valid -> sequence 0,1,2,0. SEL_W=2; out_sel never reaches 3.
- Single channel: NUM_CH=1, toggling out_ready -> data passes with 1-cycle latency, in_ready = !out_valid || out_ready.
